mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single 32-bit memory port of the multi-cycle CPU between instruction fetch (IF) and data memory access (DM).
Arbitrates both requesters round-robin and registers the winner's address, write-enable and write data. Drives mem_sel, the pos select of the 32-bit 2:1 address/data mux in front of memory. Sequences one transaction at a time through an IDLE/XFER/RESP state machine.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width of read and write data
TIMEOUT, 15, XFER cycles without mem_ready before abort (used only with MEMARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, level; held until if_done
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: IF request accepted
if_done  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched word, held until next IF completion
dm_req  in  1  data request, level; held until dm_done
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  one-cycle pulse: DM request accepted
dm_done  out  1  one-cycle pulse: dm_rdata valid / store complete
dm_rdata  out  DATA_W  load data, held until next DM completion
mem_sel  out  1  mux select: 0 = IF, 1 = DM; registered owner
mem_en  out  1  memory access active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completes access this cycle
mem_err  out  1  one-cycle pulse with done on timeout abort
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, last_owner = DM (IF wins the first conflict), every output 0, including if_rdata and dm_rdata. Reset asserted mid-transaction drops mem_en at once, aborts the transaction and emits no done.
- IDLE: at the edge where any req = 1, pick the owner.
  - Only one req high: that requester wins.
  - Both high: the requester that is not last_owner wins.
  - On the win: latch mem_sel, mem_addr, mem_wdata and mem_we into registers. mem_we = dm_we for DM and 0 for IF. Update last_owner and go to XFER.
- XFER: mem_en = 1 and the matching gnt = 1, but only in the first XFER cycle. mem_addr, mem_we and mem_wdata stay stable. When mem_ready = 1 at an edge, capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave dm_rdata unchanged) and go to RESP.
- RESP: the owner's done = 1 for exactly this cycle and mem_en = 0. Requests are not sampled here. Next state is IDLE.
- Latency:
  - Request seen at edge N gives gnt in cycle N+1.
  - With mem_ready=1 in the first XFER cycle, done comes in cycle N+2. Minimum is 3 cycles per transaction.
  - Back-to-back requests are separated by one IDLE cycle.
- The losing requester keeps its req high and wins the next arbitration in IDLE. Both requesters streaming alternate strictly IF, DM, IF, ...
- A req dropped before gnt is a protocol violation; the arbiter is not required to cancel.
- mem_sel holds its value through IDLE; it changes only when a new owner is latched.
- mem_err stays 0 when the macro is not defined.

Optional Feature:
MEMARB_TIMEOUT_EN
- Defined:
  - A 4-bit-minimum counter (wide enough for TIMEOUT) clears on XFER entry and increments each XFER cycle with mem_ready = 0.
  - When the count reaches TIMEOUT, go to RESP with the owner's rdata = 32'hDEADBEEF (loads/fetches only) and mem_err = 1 together with done.
  - mem_ready arriving in the same cycle as the timeout wins, and no error is raised.
- Undefined: no counter; XFER waits for mem_ready indefinitely; mem_err is tied to 0.

Test Plan:
- Reset then if_req=1, if_addr=32'h0000_0040, mem_ready=1 with mem_rdata=32'h2008_0005 -> if_gnt at cycle 1; if_done at cycle 2 with if_rdata=32'h2008_0005; mem_sel=0, mem_we=0.
- dm_req=1, dm_we=1, dm_addr=32'h0000_0100, dm_wdata=32'hCAFE_F00D, mem_ready=1 -> mem_sel=1, mem_we=1, mem_wdata=32'hCAFE_F00D during XFER; dm_done pulses; dm_rdata unchanged.
- Both req high right after reset -> IF granted first, then DM, then IF. Grants alternate and each requester is done exactly once per grant.
- DM load with mem_ready held low 5 cycles, then high with mem_rdata=32'h1234_5678 -> mem_en high for 6 cycles with a stable address; dm_rdata=32'h1234_5678; mem_err=0.
- rst asserted in the 2nd XFER cycle -> all outputs 0 asynchronously; no done. After release, a pending dm_req is granted normally.
- With MEMARB_TIMEOUT_EN and mem_ready stuck at 0 on an IF fetch -> after 15 XFER cycles, if_done and mem_err pulse together with if_rdata=32'hDEADBEEF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/DM arbiter for the shared memory port
// Define MEMARB_TIMEOUT_EN to abort a transfer after TIMEOUT cycles without mem_ready.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(32'hDEADBEEF);

    state_t            state;
    state_t            state_nxt;
    logic              last_owner;
    logic              sel_r;
    logic              we_r;
    logic              first_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              take;
    logic              win_dm;
    logic              finish;
    logic              timeout_hit;

    // Owner encoding: 0 = IF, 1 = DM. On conflict the side that did not own last wins.
    assign take   = (state == ST_IDLE) && (if_req || dm_req);
    assign win_dm = dm_req && (!if_req || !last_owner);
    assign finish = (state == ST_XFER) && (mem_ready || timeout_hit);

`ifdef MEMARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             err_r;

    // cnt equals the number of ready-less XFER cycles already elapsed.
    assign timeout_hit = (state == ST_XFER) && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            err_r <= 1'b0;
        end else begin
            if (take) begin
                cnt <= '0;
            end else if ((state == ST_XFER) && !mem_ready) begin
                cnt <= cnt + 1'b1;
            end
            if (finish) begin
                err_r <= !mem_ready;
            end
        end
    end

    assign mem_err = (state == ST_RESP) && err_r;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign mem_err        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (take) state_nxt = ST_XFER;
            ST_XFER: if (mem_ready || timeout_hit) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            sel_r      <= 1'b0;
            we_r       <= 1'b0;
            first_r    <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            if_rdata_r <= '0;
            dm_rdata_r <= '0;
        end else begin
            state   <= state_nxt;
            first_r <= take;
            if (take) begin
                sel_r      <= win_dm;
                last_owner <= win_dm;
                addr_r     <= win_dm ? dm_addr : if_addr;
                wdata_r    <= win_dm ? dm_wdata : '0;
                we_r       <= win_dm && dm_we;
            end
            // Stores never touch dm_rdata; an abort returns the marker word.
            if (finish) begin
                if (!sel_r) begin
                    if_rdata_r <= mem_ready ? mem_rdata : ABORT_WORD;
                end else if (!we_r) begin
                    dm_rdata_r <= mem_ready ? mem_rdata : ABORT_WORD;
                end
            end
        end
    end

    assign if_gnt    = (state == ST_XFER) && first_r && !sel_r;
    assign dm_gnt    = (state == ST_XFER) && first_r && sel_r;
    assign if_done   = (state == ST_RESP) && !sel_r;
    assign dm_done   = (state == ST_RESP) && sel_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign mem_sel   = sel_r;
    assign mem_en    = (state == ST_XFER);
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction schedule model
module tb_mem_port_arbiter;

`ifdef MEMARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_done;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic        dm_gnt, dm_done;
    logic [31:0] dm_rdata;
    logic        mem_sel, mem_en, mem_we, mem_err, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_err(mem_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Schedule of the current transaction in absolute cycle numbers.
    int          cyc = 0;
    int          gnt_cyc = -100, ready_cyc = -100, done_cyc = -100, next_arb = 0;
    bit          owner = 1'b0, last_owner = 1'b1, exp_sel = 1'b0, exp_we = 1'b0, timed_out = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_if_rd = '0, exp_dm_rd = '0, rd_at_ready = '0;
    bit          allow_new = 1'b0, stream = 1'b0, force_rd_en = 1'b0;
    int          force_wait = -1;
    logic [31:0] force_rd = '0;
    int          n_dm_done = 0;

    function automatic int pick_wait();
        int tbl [8] = '{0, 1, 2, 3, 5, 14, 15, 20};
        if (TO_EN) return tbl[$urandom_range(0, 7)];
        return $urandom_range(0, 5);
    endfunction

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = $urandom;
    endtask

    task automatic new_dm();
        dm_req   = 1'b1;
        dm_we    = $urandom_range(0, 1);
        dm_addr  = $urandom;
        dm_wdata = $urandom;
    endtask

    task automatic check_cycle(input int c);
        bit          in_x;
        bit          in_b;
        logic [31:0] v;
        in_x = (c >= gnt_cyc) && (c < done_cyc);
        in_b = (c >= gnt_cyc) && (c <= done_cyc);
        if (c == done_cyc) begin
            v = timed_out ? 32'hDEADBEEF : rd_at_ready;
            if (!owner) exp_if_rd = v;
            else begin
                if (!exp_we) exp_dm_rd = v;
                n_dm_done++;
            end
        end
        check_eq("if_gnt",  if_gnt,  (c == gnt_cyc) && !owner);
        check_eq("dm_gnt",  dm_gnt,  (c == gnt_cyc) && owner);
        check_eq("if_done", if_done, (c == done_cyc) && !owner);
        check_eq("dm_done", dm_done, (c == done_cyc) && owner);
        check_eq("mem_en",  mem_en,  in_x);
        check_eq("busy",    busy,    in_b);
        check_eq("mem_err", mem_err, (c == done_cyc) && timed_out);
        check_eq("mem_sel", mem_sel, exp_sel);
        check_eq("if_rdata", if_rdata, exp_if_rd);
        check_eq("dm_rdata", dm_rdata, exp_dm_rd);
        if (in_x) begin
            check_eq("mem_addr", mem_addr, exp_addr);
            check_eq("mem_we",   mem_we,   exp_we);
            if (exp_we) check_eq("mem_wdata", mem_wdata, exp_wdata);
        end
    endtask

    task automatic drive(input int c);
        int w;
        if (if_req && c == done_cyc && !owner) begin
            if (stream || (allow_new && $urandom_range(0, 1) == 1)) new_if();
            else if_req = 1'b0;
        end else if (!if_req && allow_new && $urandom_range(0, 2) == 0) new_if();
        if (dm_req && c == done_cyc && owner) begin
            if (stream || (allow_new && $urandom_range(0, 1) == 1)) new_dm();
            else dm_req = 1'b0;
        end else if (!dm_req && allow_new && $urandom_range(0, 2) == 0) new_dm();

        if (c >= next_arb && (if_req || dm_req)) begin
            owner      = (if_req && dm_req) ? !last_owner : dm_req;
            last_owner = owner;
            exp_sel    = owner;
            exp_addr   = owner ? dm_addr : if_addr;
            exp_we     = owner && dm_we;
            exp_wdata  = dm_wdata;
            w          = (force_wait >= 0) ? force_wait : pick_wait();
            gnt_cyc    = c + 1;
            if (TO_EN && w >= TIMEOUT) begin
                timed_out = 1'b1;
                ready_cyc = -100;
                done_cyc  = gnt_cyc + TIMEOUT;
            end else begin
                timed_out = 1'b0;
                ready_cyc = gnt_cyc + w;
                done_cyc  = ready_cyc + 1;
            end
            next_arb = done_cyc + 1;
        end

        if (c >= gnt_cyc && c < done_cyc) mem_ready = (c == ready_cyc);
        else mem_ready = $urandom_range(0, 1);
        mem_rdata = (c == ready_cyc && force_rd_en) ? force_rd : $urandom;
        if (c == ready_cyc) rd_at_ready = mem_rdata;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_cycle(cyc);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            drive(cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_if_gnt"},  if_gnt, 0);
        check_eq({tag, "_dm_gnt"},  dm_gnt, 0);
        check_eq({tag, "_if_done"}, if_done, 0);
        check_eq({tag, "_dm_done"}, dm_done, 0);
        check_eq({tag, "_if_rdata"}, if_rdata, 0);
        check_eq({tag, "_dm_rdata"}, dm_rdata, 0);
        check_eq({tag, "_mem_sel"}, mem_sel, 0);
        check_eq({tag, "_mem_en"},  mem_en, 0);
        check_eq({tag, "_mem_we"},  mem_we, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
        check_eq({tag, "_mem_err"}, mem_err, 0);
        check_eq({tag, "_busy"},    busy, 0);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        cyc = 0;

        // First fetch straight after reset, memory ready immediately.
        new_if();
        if_addr     = 32'h0000_0040;
        force_wait  = 0;
        force_rd_en = 1'b1;
        force_rd    = 32'h2008_0005;
        drive(cyc);
        run(5);
        check_eq("first_fetch", if_rdata, 32'h2008_0005);

        // Single store: dm_rdata must stay at its reset value.
        tick();
        new_dm();
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0100;
        dm_wdata = 32'hCAFE_F00D;
        drive(cyc);
        run(5);
        check_eq("store_keeps_rdata", dm_rdata, 32'h0);

        // Both requesters streaming, then free-running random traffic.
        force_wait  = -1;
        force_rd_en = 1'b0;
        tick();
        stream = 1'b1;
        new_if();
        new_dm();
        drive(cyc);
        run(60);
        stream    = 1'b0;
        allow_new = 1'b1;
        run(1500);
        allow_new = 1'b0;
        run(60);

        // Slow load: five ready-less cycles before completion.
        tick();
        new_dm();
        dm_we       = 1'b0;
        force_wait  = 5;
        force_rd_en = 1'b1;
        force_rd    = 32'h1234_5678;
        drive(cyc);
        run(9);
        check_eq("slow_load", dm_rdata, 32'h1234_5678);
        check_eq("slow_load_err", mem_err, 0);

        // Reset in the second XFER cycle of a load that keeps its request up.
        tick();
        new_dm();
        dm_we      = 1'b0;
        force_wait = 10;
        drive(cyc);
        run(1);
        tick();
        check_eq("rst_window", cyc, gnt_cyc + 1);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        check_zero("rst_held");
        rst        = 1'b0;
        cyc        = cyc + 2;
        gnt_cyc    = -100;
        ready_cyc  = -100;
        done_cyc   = -100;
        next_arb   = cyc;
        last_owner = 1'b1;
        exp_sel    = 1'b0;
        exp_if_rd  = '0;
        exp_dm_rd  = '0;
        force_wait = 1;
        force_rd   = 32'h0BAD_F00D;
        base       = n_dm_done;
        drive(cyc);
        run(8);
        check_eq("post_rst_done_count", n_dm_done - base, 1);
        check_eq("post_rst_rdata", dm_rdata, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
